// File: rtl/mul_seq_ctrl.sv
// Sequential 32x32 RV32M multiplier (MUL/MULH/MULHSU/MULHU) built around a
// single time-shared carry-lookahead adder; fixed 36-cycle latency.

module mul_seq_cla32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  logic [31:0] g, p, c_bit;
  logic [7:0]  gg, gp;
  logic [8:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  // 4-bit lookahead groups; group carries resolved in a second level below
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_grp
      localparam int B = 4 * gi;
      assign gg[gi] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                    | (p[B+3] & p[B+2] & p[B+1] & g[B]);
      assign gp[gi] = &p[B+3:B];
      assign c_bit[B]   = gc[gi];
      assign c_bit[B+1] = g[B] | (p[B] & gc[gi]);
      assign c_bit[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & gc[gi]);
      assign c_bit[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                        | (p[B+2] & p[B+1] & p[B] & gc[gi]);
    end
  endgenerate

  always_comb begin
    gc[0] = cin;
    for (int k = 0; k < 8; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
  end

  assign sum  = p ^ c_bit;
  assign cout = gc[8];
endmodule

module mul_seq_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, PREP_A, PREP_B, MULT, NEG_LO, NEG_HI, DONE} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  op_reg, op_next;
  logic [31:0] rs1_reg, rs1_next, rs2_reg, rs2_next;
  logic [31:0] mcand_reg, mcand_next, hi_reg, hi_next, lo_reg, lo_next;
  logic        neg_reg, neg_next, carry_reg, carry_next;
  logic [4:0]  cnt_reg, cnt_next;

  logic [31:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        rs1_neg, rs2_neg;

  mul_seq_cla32 u_cla (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // rs1 is signed for all but MULHU; rs2 only for MUL/MULH
  assign rs1_neg = (op_reg != 2'b11) && rs1_reg[31];
  assign rs2_neg = !op_reg[1] && rs2_reg[31];

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    rs1_next   = rs1_reg;
    rs2_next   = rs2_reg;
    mcand_next = mcand_reg;
    hi_next    = hi_reg;
    lo_next    = lo_reg;
    neg_next   = neg_reg;
    carry_next = carry_reg;
    cnt_next   = cnt_reg;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          op_next    = op;
          rs1_next   = rs1;
          rs2_next   = rs2;
          state_next = PREP_A;
        end
      end
      PREP_A: begin
        add_a      = ~rs1_reg;
        add_cin    = 1'b1;
        mcand_next = rs1_neg ? add_sum : rs1_reg;
        state_next = PREP_B;
      end
      PREP_B: begin
        add_a      = ~rs2_reg;
        add_cin    = 1'b1;
        lo_next    = rs2_neg ? add_sum : rs2_reg;
        hi_next    = '0;
        neg_next   = rs1_neg ^ rs2_neg;
        cnt_next   = '0;
        state_next = MULT;
      end
      MULT: begin
        add_a    = hi_reg;
        add_b    = lo_reg[0] ? mcand_reg : '0;
        hi_next  = {add_cout, add_sum[31:1]};
        lo_next  = {add_sum[0], lo_reg[31:1]};
        cnt_next = cnt_reg + 5'd1;
        if (cnt_reg == 5'd31) state_next = NEG_LO;
      end
      NEG_LO: begin
        // 64-bit negate: low word first, its carry feeds the high word
        add_a   = ~lo_reg;
        add_cin = 1'b1;
        if (neg_reg) begin
          lo_next    = add_sum;
          carry_next = add_cout;
        end else begin
          carry_next = 1'b0;
        end
        state_next = NEG_HI;
      end
      NEG_HI: begin
        add_a   = ~hi_reg;
        add_cin = carry_reg;
        if (neg_reg) hi_next = add_sum;
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      op_reg    <= '0;
      rs1_reg   <= '0;
      rs2_reg   <= '0;
      mcand_reg <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      neg_reg   <= 1'b0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      rs1_reg   <= rs1_next;
      rs2_reg   <= rs2_next;
      mcand_reg <= mcand_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
      neg_reg   <= neg_next;
      carry_reg <= carry_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == DONE);
  assign result    = out_valid ? ((op_reg == 2'b00) ? lo_reg : hi_reg) : '0;
endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed vector table, randomized ops
// against a 64-bit arithmetic reference, backpressure and reset corner cases.

module tb_mul_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [1:0]  op = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference: sign- or zero-extend each operand to 64 bits, multiply, pick a word
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, prod;
    ea   = (o != 2'b11 && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
    eb   = (o[1] == 1'b0 && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
    prod = ea * eb;
    return (o == 2'b00) ? prod[31:0] : prod[63:32];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Waits (bounded) for out_valid; returns edges since the acceptance edge
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic accept(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    chk({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
    op = o; rs1 = a; rs2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op  = 2'($urandom);
    rs1 = $urandom;
    rs2 = $urandom;
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    int n;
    logic [31:0] got;
    accept(o, a, b, tag);
    wait_valid(n);
    got = result;
    chk({tag, " latency"}, 32'(n), 32'd36);
    chk({tag, " result"}, got, exp);
    $display("txn %s op=%0d rs1=%h rs2=%h result=%h expected=%h latency=%0d",
             tag, o, a, b, got, exp, n);
    @(posedge clk); #1;
    chk({tag, " pulse_end"}, {31'b0, out_valid}, 32'd0);
    chk({tag, " result_idle"}, result, 32'd0);
  endtask

  initial begin
    int n;
    int pulses;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    vecs[0]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB};
    vecs[2]  = '{2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[3]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[4]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    vecs[5]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[6]  = '{2'b10, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001};
    vecs[7]  = '{2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[8]  = '{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[9]  = '{2'b00, 32'h0000_0006, 32'h0000_0007, 32'h0000_002A};
    vecs[10] = '{2'b11, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000};
    vecs[11] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[12] = '{2'b11, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", {31'b0, in_ready}, 32'd1);
    chk("reset out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset result", result, 32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom);
      ra = pick_operand();
      rb = pick_operand();
      run_op(ro, ra, rb, ref_mul(ro, ra, rb), $sformatf("rnd%0d", i));
    end

    // Backpressure in DONE with in_valid toggling
    out_ready = 1'b0;
    accept(2'b01, 32'hFFFF_FFFD, 32'h7, "bp");
    wait_valid(n);
    chk("bp latency", 32'(n), 32'd36);
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      op  = 2'($urandom);
      rs1 = $urandom;
      rs2 = $urandom;
      @(posedge clk); #1;
      chk("bp out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp result", result, 32'hFFFF_FFFF);
      chk("bp in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp busy", {31'b0, busy}, 32'd1);
    end
    $display("txn bp op=1 rs1=fffffffd rs2=00000007 result held 5 cycles");
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp handshake in_ready", {31'b0, in_ready}, 32'd1);
    chk("bp handshake out_valid", {31'b0, out_valid}, 32'd0);
    chk("bp handshake busy", {31'b0, busy}, 32'd0);

    // Reset at MULT iteration 10 (acceptance edge + 13)
    accept(2'b00, 32'h0000_1234, 32'h0000_5678, "rst_mult");
    repeat (12) @(posedge clk);
    #1;
    chk("rst_mult busy_before", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_mult busy", {31'b0, busy}, 32'd0);
    chk("rst_mult in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_mult out_valid", {31'b0, out_valid}, 32'd0);
    $display("txn rst_mult aborted at iteration 10");
    run_op(2'b00, 32'h6, 32'h7, 32'h0000_002A, "post_rst");

    // Reset while a result is pending in DONE
    out_ready = 1'b0;
    accept(2'b11, 32'hFFFF_FFFF, 32'h2, "rst_done");
    wait_valid(n);
    chk("rst_done reached", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    chk("rst_done out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_done result", result, 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    chk("rst_done no_pulse", 32'(pulses), 32'd0);
    chk("rst_done busy", {31'b0, busy}, 32'd0);
    $display("txn rst_done result discarded");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 op  input  2  00 MUL (low, s×s), 01 MULH (high, s×s), 10 MULHSU (high, rs1 signed × rs2 unsigned), 11 MULHU (high, u×u).
REQ-007 rs1, rs2  input  32 each  operands.
REQ-008 out_valid  output  1  result present.
REQ-009 out_ready  input  1  consumer takes result.
REQ-010 result  output  32  selected product word.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 The block SHALL contain exactly one instance of the team's 32-bit carry-lookahead adder, time-shared by all states; no other 32-bit add/subtract logic.
REQ-013 States SHALL be IDLE, PREP_A, PREP_B, MULT, NEG_LO, NEG_HI, DONE.
REQ-014 in_ready SHALL be high only in IDLE; acceptance = in_valid & in_ready at a rising edge, capturing op, rs1, rs2; IDLE -> PREP_A.
REQ-015 Operand changes after acceptance SHALL have no effect on the result.
REQ-016 PREP_A: mcand <= |rs1| if rs1 is signed (op != 11) and rs1[31]=1, computed as ~rs1 + 1 on the adder; otherwise rs1 unchanged; -> PREP_B.
REQ-017 PREP_B: same for rs2 into mplier, signed only for op 00/01; sign flag neg <= xor of the negated operand signs; -> MULT, iteration counter <= 0.
REQ-018 MULT: each cycle {c, hi} = hi + (lo[0] ? mcand : 0) on the adder (c = adder carry out), then {c, hi, lo} shifted right 1; lo initialised to mplier, hi to 0 at PREP_B exit.
REQ-019 MULT SHALL last exactly 32 cycles (counter 0..31), then -> NEG_LO.
REQ-020 NEG_LO: if neg, lo <= ~lo + 1 on the adder, latching carry out; else lo unchanged, latched carry = 0; -> NEG_HI.
REQ-021 NEG_HI: if neg, hi <= ~hi + latched carry; else unchanged; -> DONE.
REQ-022 Every path through the states SHALL be taken regardless of operand values, so out_valid rises on the 36th rising edge after the acceptance edge.
REQ-023 DONE: out_valid = 1; result = lo for op 00, hi otherwise; result and out_valid SHALL hold stable until out_valid & out_ready.
REQ-024 On out_valid & out_ready: DONE -> IDLE; no new request is accepted in the same cycle (in_ready = 0 in DONE).
REQ-025 in_valid outside IDLE SHALL be ignored without side effects.
REQ-026 |0x80000000| SHALL be treated as unsigned 2^31 (no saturation); products follow RV32M results exactly, including 0x80000000 × 0xFFFFFFFF signed.
REQ-027 result SHALL read 0 whenever out_valid is 0.

Reset
REQ-028 When rst_n = 0 at a rising edge: state <= IDLE, in_ready = 1, out_valid = 0, busy = 0, result = 0, all internal registers 0.
REQ-029 Reset asserted in any state, including mid-MULT or DONE with pending result, SHALL abort the operation and discard the result; no output pulse follows.
REQ-030 The first request after reset release SHALL complete with correct value and 36-cycle latency.

Verification
REQ-031 MULHU 0xFFFFFFFF × 0xFFFFFFFF, out_ready = 1 -> result 0xFFFFFFFE, out_valid exactly 36 edges after acceptance, one cycle long.
REQ-032 MUL rs1 = 0xFFFFFFFD (-3), rs2 = 7 -> 0xFFFFFFEB; same operands with MULH -> 0xFFFFFFFF.
REQ-033 MULH 0x80000000 × 0x80000000 -> 0x40000000; MUL with the same operands -> 0x00000000.
REQ-034 MULHSU rs1 = 0xFFFFFFFF, rs2 = 0xFFFFFFFF -> 0xFFFFFFFF; MULHSU 2 × 0x80000000 -> 0x00000001.
REQ-035 Backpressure: out_ready low 5 cycles in DONE with in_valid toggling -> result and out_valid stable, in_ready 0, nothing accepted; handshake -> IDLE next edge.
REQ-036 rst_n low at MULT iteration 10 -> next edge busy 0, in_ready 1, out_valid 0; subsequent MUL 6 × 7 -> 0x0000002A after 36 edges.
